// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares one single-ported RAM between the IF-stage fetch port and the MEM-stage load/store
//   port. Each access holds ram_enable for MEM_LATENCY cycles with the request fields latched,
//   then returns read data and pulses the requester's valid. MEM wins arbitration unless IF has
//   waited through STARVE_LIMIT consecutive MEM grants.
// Ports
//   clk_i, rst_ni               clock (rising edge), asynchronous active-low reset
//   if_req_i, if_addr_i         fetch request/address, held until if_valid_o
//   if_gnt_o, if_valid_o        fetch started / fetch done (one-cycle pulses)
//   if_rdata_o                  last fetched word
//   mem_req_i .. mem_wdata_i    load/store request and its controls
//   mem_gnt_o, mem_valid_o      data access started / done (one-cycle pulses)
//   mem_rdata_o                 last load data
//   ram_*_o, ram_rdata_i        RAM interface
//   stall_if_o, stall_mem_o     per-stage stalls while an access is outstanding
module ram_port_arbiter #(
  parameter int unsigned MEM_LATENCY  = 2,
  parameter int unsigned ADDR_W       = 9,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_valid_o,
  output logic [31:0]       if_rdata_o,
  input  logic              mem_req_i,
  input  logic              mem_rw_i,
  input  logic [1:0]        mem_size_i,
  input  logic              mem_se_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  output logic              mem_gnt_o,
  output logic              mem_valid_o,
  output logic [31:0]       mem_rdata_o,
  output logic              ram_enable_o,
  output logic              ram_rw_o,
  output logic [1:0]        ram_size_o,
  output logic              ram_se_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [31:0]       ram_wdata_o,
  input  logic [31:0]       ram_rdata_i,
  output logic              stall_if_o,
  output logic              stall_mem_o
);

  localparam int unsigned LatW    = $clog2(MEM_LATENCY + 1);
  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);
  localparam logic [LatW-1:0]    LatInit   = LatW'(MEM_LATENCY);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);

  typedef enum logic [1:0] {StIdle, StBusyIf, StBusyMem} state_e;

  state_e              state_q;
  logic [LatW-1:0]     lat_cnt_q;
  logic [StarveW-1:0]  starve_q;
  logic                ram_enable_q, ram_rw_q, ram_se_q;
  logic [1:0]          ram_size_q;
  logic [ADDR_W-1:0]   ram_addr_q;
  logic [31:0]         ram_wdata_q;
  logic                if_gnt_q, if_valid_q, mem_gnt_q, mem_valid_q;
  logic [31:0]         if_rdata_q, mem_rdata_q;

  logic if_elig, mem_elig, grant_mem, grant_if;

  // A requester is not eligible in its valid cycle, so a still-asserted req is not re-granted
  // before the stage has consumed the result.
  always_comb begin
    if_elig   = if_req_i & ~if_valid_q;
    mem_elig  = mem_req_i & ~mem_valid_q;
    grant_mem = (state_q == StIdle) & mem_elig & (~if_elig | (starve_q < StarveMax));
    grant_if  = (state_q == StIdle) & ~grant_mem & if_elig;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      lat_cnt_q    <= '0;
      starve_q     <= '0;
      ram_enable_q <= 1'b0;
      ram_rw_q     <= 1'b0;
      ram_size_q   <= 2'b00;
      ram_se_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      if_gnt_q     <= 1'b0;
      if_valid_q   <= 1'b0;
      mem_gnt_q    <= 1'b0;
      mem_valid_q  <= 1'b0;
      if_rdata_q   <= '0;
      mem_rdata_q  <= '0;
    end else begin
      if_gnt_q    <= 1'b0;
      mem_gnt_q   <= 1'b0;
      if_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant_mem) begin
            state_q      <= StBusyMem;
            mem_gnt_q    <= 1'b1;
            ram_enable_q <= 1'b1;
            ram_rw_q     <= mem_rw_i;
            ram_size_q   <= mem_size_i;
            ram_se_q     <= mem_se_i;
            ram_addr_q   <= mem_addr_i;
            ram_wdata_q  <= mem_wdata_i;
            lat_cnt_q    <= LatInit;
            // Count only grants that made a waiting fetch wait longer.
            if (!if_req_i) begin
              starve_q <= '0;
            end else if (starve_q != StarveMax) begin
              starve_q <= starve_q + 1'b1;
            end
          end else if (grant_if) begin
            state_q      <= StBusyIf;
            if_gnt_q     <= 1'b1;
            ram_enable_q <= 1'b1;
            ram_rw_q     <= 1'b0;
            ram_size_q   <= 2'b10;
            ram_se_q     <= 1'b0;
            ram_addr_q   <= if_addr_i;
            ram_wdata_q  <= '0;
            lat_cnt_q    <= LatInit;
            starve_q     <= '0;
          end
        end
        StBusyIf, StBusyMem: begin
          lat_cnt_q <= lat_cnt_q - 1'b1;
          if (lat_cnt_q == LatW'(1)) begin
            ram_enable_q <= 1'b0;
            ram_rw_q     <= 1'b0;
            state_q      <= StIdle;
            if (state_q == StBusyIf) begin
              if_rdata_q <= ram_rdata_i;
              if_valid_q <= 1'b1;
            end else begin
              mem_valid_q <= 1'b1;
              // Stores leave the last load data untouched.
              if (!ram_rw_q) mem_rdata_q <= ram_rdata_i;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    if_gnt_o     = if_gnt_q;
    if_valid_o   = if_valid_q;
    if_rdata_o   = if_rdata_q;
    mem_gnt_o    = mem_gnt_q;
    mem_valid_o  = mem_valid_q;
    mem_rdata_o  = mem_rdata_q;
    ram_enable_o = ram_enable_q;
    ram_rw_o     = ram_rw_q;
    ram_size_o   = ram_size_q;
    ram_se_o     = ram_se_q;
    ram_addr_o   = ram_addr_q;
    ram_wdata_o  = ram_wdata_q;
    // Stalls are gated by reset so the pipeline is free while the arbiter is held.
    stall_if_o   = rst_ni & if_req_i & ~if_valid_q;
    stall_mem_o  = rst_ni & mem_req_i & ~mem_valid_q;
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with MEM_LATENCY=2, ADDR_W=9, STARVE_LIMIT=4.
// Inputs are driven 1 time unit after the rising edge; outputs are checked there too.
module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [8:0]  if_addr;
  logic        if_gnt, if_valid;
  logic [31:0] if_rdata;
  logic        mem_req, mem_rw, mem_se;
  logic [1:0]  mem_size;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt, mem_valid;
  logic [31:0] mem_rdata;
  logic        ram_enable, ram_rw, ram_se;
  logic [1:0]  ram_size;
  logic [8:0]  ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic        stall_if, stall_mem;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(
    .MEM_LATENCY (2),
    .ADDR_W      (9),
    .STARVE_LIMIT(4)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .if_req_i    (if_req),
    .if_addr_i   (if_addr),
    .if_gnt_o    (if_gnt),
    .if_valid_o  (if_valid),
    .if_rdata_o  (if_rdata),
    .mem_req_i   (mem_req),
    .mem_rw_i    (mem_rw),
    .mem_size_i  (mem_size),
    .mem_se_i    (mem_se),
    .mem_addr_i  (mem_addr),
    .mem_wdata_i (mem_wdata),
    .mem_gnt_o   (mem_gnt),
    .mem_valid_o (mem_valid),
    .mem_rdata_o (mem_rdata),
    .ram_enable_o(ram_enable),
    .ram_rw_o    (ram_rw),
    .ram_size_o  (ram_size),
    .ram_se_o    (ram_se),
    .ram_addr_o  (ram_addr),
    .ram_wdata_o (ram_wdata),
    .ram_rdata_i (ram_rdata),
    .stall_if_o  (stall_if),
    .stall_mem_o (stall_mem)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int got_if [6];
    int exp_if [6];
    int n_grants;
    exp_if = '{0, 0, 0, 0, 1, 0};

    // 1: reset with both requests high, then MEM wins the first arbitration.
    rst_n = 1'b0;
    if_req = 1'b1; if_addr = 9'h000;
    mem_req = 1'b1; mem_rw = 1'b0; mem_size = 2'b10; mem_se = 1'b0;
    mem_addr = 9'h030; mem_wdata = 32'h0;
    ram_rdata = 32'hA5A5A5A5;
    step(); step();
    check("rst_ram_enable", 32'(ram_enable), 0);
    check("rst_ram_addr", 32'(ram_addr), 0);
    check("rst_ram_ctrl", {27'b0, ram_rw, ram_size, ram_se}, 0);
    check("rst_gnt_valid", {28'b0, if_gnt, if_valid, mem_gnt, mem_valid}, 0);
    check("rst_rdata", if_rdata | mem_rdata | ram_wdata, 0);
    check("rst_stalls", {30'b0, stall_if, stall_mem}, 0);
    #2 rst_n = 1'b1;
    step();
    check("t1_mem_gnt", 32'(mem_gnt), 1);
    check("t1_if_gnt", 32'(if_gnt), 0);
    check("t1_ram_addr", 32'(ram_addr), 32'h030);
    // Both requesters drop mid-access; the access must still complete.
    if_req = 1'b0; mem_req = 1'b0;
    step();
    step();
    check("t1_mem_valid", 32'(mem_valid), 1);
    check("t1_mem_rdata", mem_rdata, 32'hA5A5A5A5);
    check("t1_ram_enable_off", 32'(ram_enable), 0);
    step();
    check("t1_no_regrant", {30'b0, if_gnt, mem_gnt}, 0);
    step();

    // 2: fetch only.
    if_req = 1'b1; if_addr = 9'h004; ram_rdata = 32'h00500093;
    #1 check("t2_stall_T", 32'(stall_if), 1);
    step();
    check("t2_if_gnt", 32'(if_gnt), 1);
    check("t2_mem_gnt", 32'(mem_gnt), 0);
    check("t2_ram_enable1", 32'(ram_enable), 1);
    check("t2_ram_addr", 32'(ram_addr), 32'h004);
    check("t2_ram_ctrl", {27'b0, ram_rw, ram_size, ram_se}, 32'b0100);
    check("t2_stall_T1", 32'(stall_if), 1);
    if_addr = 9'h1FC;
    step();
    check("t2_gnt_pulse", 32'(if_gnt), 0);
    check("t2_ram_enable2", 32'(ram_enable), 1);
    check("t2_addr_held", 32'(ram_addr), 32'h004);
    check("t2_valid_early", 32'(if_valid), 0);
    check("t2_stall_T2", 32'(stall_if), 1);
    step();
    check("t2_if_valid", 32'(if_valid), 1);
    check("t2_if_rdata", if_rdata, 32'h00500093);
    check("t2_ram_enable3", 32'(ram_enable), 0);
    check("t2_stall_T3", 32'(stall_if), 0);
    if_req = 1'b0;
    step();
    check("t2_valid_pulse", 32'(if_valid), 0);
    check("t2_no_regrant", 32'(if_gnt), 0);
    step();

    // 3: simultaneous requests; MEM first (byte load, sign-extended), then IF.
    if_req = 1'b1; if_addr = 9'h008;
    mem_req = 1'b1; mem_rw = 1'b0; mem_size = 2'b00; mem_se = 1'b1; mem_addr = 9'h020;
    ram_rdata = 32'h12345678;
    step();
    check("t3_mem_gnt", {30'b0, mem_gnt, if_gnt}, 32'b10);
    check("t3_ram_addr", 32'(ram_addr), 32'h020);
    check("t3_ram_ctrl", {27'b0, ram_rw, ram_size, ram_se}, 32'b0001);
    step();
    check("t3_stall_mem_T2", 32'(stall_mem), 1);
    step();
    check("t3_mem_valid", 32'(mem_valid), 1);
    check("t3_mem_rdata", mem_rdata, 32'h12345678);
    check("t3_stalls_T3", {30'b0, stall_if, stall_mem}, 32'b10);
    mem_req = 1'b0; ram_rdata = 32'hCAFEF00D;
    step();
    check("t3_if_gnt", 32'(if_gnt), 1);
    check("t3_ram_addr_if", 32'(ram_addr), 32'h008);
    step();
    check("t3_stall_if_T5", 32'(stall_if), 1);
    step();
    check("t3_if_valid", 32'(if_valid), 1);
    check("t3_if_rdata", if_rdata, 32'hCAFEF00D);
    check("t3_stall_if_T6", 32'(stall_if), 0);
    if_req = 1'b0;
    step();

    // 4: word store; mem_rdata must keep the previous load data.
    mem_req = 1'b1; mem_rw = 1'b1; mem_size = 2'b10; mem_se = 1'b0; mem_addr = 9'h010;
    mem_wdata = 32'hDEADBEEF; ram_rdata = 32'h11111111;
    step();
    check("t4_mem_gnt", 32'(mem_gnt), 1);
    check("t4_ram_ctrl1", {27'b0, ram_rw, ram_size, ram_se}, 32'b1100);
    check("t4_ram_wdata1", ram_wdata, 32'hDEADBEEF);
    check("t4_ram_addr", 32'(ram_addr), 32'h010);
    mem_wdata = 32'h0; mem_rw = 1'b0;
    step();
    check("t4_ram_rw2", 32'(ram_rw), 1);
    check("t4_ram_wdata2", ram_wdata, 32'hDEADBEEF);
    step();
    check("t4_mem_valid", 32'(mem_valid), 1);
    check("t4_mem_rdata_kept", mem_rdata, 32'h12345678);
    check("t4_ram_rw_off", 32'(ram_rw), 0);
    mem_req = 1'b0;
    step(); step();

    // 5: starvation guard. MEM requests continuously; IF is pending except in MEM's valid
    // cycle, so every MEM grant is made with if_req high.
    mem_req = 1'b1; mem_rw = 1'b0; mem_size = 2'b10; mem_addr = 9'h040;
    if_req = 1'b1; if_addr = 9'h00C;
    n_grants = 0;
    for (int cyc = 0; cyc < 200 && n_grants < 6; cyc++) begin
      step();
      if (mem_gnt || if_gnt) begin
        got_if[n_grants] = int'(if_gnt);
        n_grants++;
      end
      if_req = ~mem_valid;
    end
    check("t5_grant_count", 32'(n_grants), 6);
    for (int k = 0; k < 6; k++) begin
      if (k < n_grants) check($sformatf("t5_grant%0d_is_if", k), 32'(got_if[k]), 32'(exp_if[k]));
    end
    mem_req = 1'b0; if_req = 1'b0;
    step(); step(); step(); step();

    // 6: reset mid-load abandons the access; a pending fetch is served after release.
    mem_req = 1'b1; mem_rw = 1'b0; mem_addr = 9'h050;
    step();
    check("t6_mem_gnt", 32'(mem_gnt), 1);
    check("t6_ram_enable", 32'(ram_enable), 1);
    mem_req = 1'b0; if_req = 1'b1; if_addr = 9'h014; ram_rdata = 32'h0BADF00D;
    rst_n = 1'b0;
    #1;
    check("t6_rst_ram_enable", 32'(ram_enable), 0);
    check("t6_rst_stall_if", 32'(stall_if), 0);
    step();
    #1 rst_n = 1'b1;
    step();
    check("t6_if_gnt", 32'(if_gnt), 1);
    check("t6_no_mem_valid1", 32'(mem_valid), 0);
    step();
    check("t6_no_mem_valid2", 32'(mem_valid), 0);
    step();
    check("t6_if_valid", 32'(if_valid), 1);
    check("t6_if_rdata", if_rdata, 32'h0BADF00D);
    check("t6_no_mem_valid3", 32'(mem_valid), 0);
    if_req = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
